// File: rtl/csr_access_unit_pkg.sv
// Shared constants for the CSR access unit: funct3 encodings, FSM state codes,
// privilege levels and the illegal-instruction cause.
package csr_access_unit_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  // Low two funct3 bits select the operation; bit 2 selects the immediate form.
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam int CAUSE_ILLEGAL_INSN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Execute-stage request/response handshake plus CSR file read/write port.
// slave = the access unit, master = whoever drives requests and models the CSR file.
interface csr_access_unit_if #(parameter int XLEN = 64);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      funct3_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [4:0]      zimm_i;
  logic [4:0]      rd_idx_i;
  logic [1:0]      priv_i;
  logic            flush_i;
  logic [11:0]     csr_raddr_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic [11:0]     csr_waddr_o;
  logic            csr_wen_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_rdata_o;
  logic            exception_o;
  logic [XLEN-1:0] cause_o;

  modport slave (
    input  req_valid_i, funct3_i, csr_addr_i, rs1_data_i, zimm_i, rd_idx_i, priv_i,
           flush_i, csr_rdata_i, resp_ready_i,
    output req_ready_o, csr_raddr_o, csr_waddr_o, csr_wen_o, csr_wdata_o,
           resp_valid_o, resp_rdata_o, exception_o, cause_o
  );

  modport master (
    output req_valid_i, funct3_i, csr_addr_i, rs1_data_i, zimm_i, rd_idx_i, priv_i,
           flush_i, csr_rdata_i, resp_ready_i,
    input  req_ready_o, csr_raddr_o, csr_waddr_o, csr_wen_o, csr_wdata_o,
           resp_valid_o, resp_rdata_o, exception_o, cause_o
  );
endinterface

// File: rtl/csr_access_unit_check.sv
// Combinational legality and write-enable decision for a Zicsr request.
// Behaviour for writes to read-only CSRs depends on CSR_RO_CHECK_EN.
module csr_access_check
  import csr_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [11:0] addr,
  input  logic [4:0]  zimm,
  input  logic [1:0]  priv,
  output logic        legal,
  output logic        wr_en
);

  logic bad_op;
  logic bad_priv;
  logic wr_req;
  logic ro;

  assign bad_op   = funct3[1:0] == 2'b00;
  assign bad_priv = addr[9:8] > priv;
  // Set/clear with rs1 index x0 (or zimm 0) is a pure read.
  assign wr_req   = (funct3[1:0] == OP_RW) || (zimm != 5'd0);
  assign ro       = is_read_only(addr);

`ifdef CSR_RO_CHECK_EN
  assign legal = !bad_op && !bad_priv && !(wr_req && ro);
  assign wr_en = wr_req;
`else
  assign legal = !bad_op && !bad_priv;
  assign wr_en = wr_req && !ro;
`endif

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer: accept -> READ -> WRITE -> RESP, response at cycle 3
// (cycle 1 when illegal); holds the response until resp_ready_i. Optional macro: CSR_RO_CHECK_EN.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int ILLEGAL_CAUSE = CAUSE_ILLEGAL_INSN
) (
  input  logic              clock,
  input  logic              reset_n,
  csr_access_unit_if.slave  bus
);

  state_t          state_q, state_d;
  logic            legal;
  logic            wr_en;
  logic            accept;
  logic [11:0]     addr_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] old_q;
  logic            wen_q;
  logic            exc_q;
  logic [XLEN-1:0] wdata;

  csr_access_check u_check (
    .funct3 (bus.funct3_i),
    .addr   (bus.csr_addr_i),
    .zimm   (bus.zimm_i),
    .priv   (bus.priv_i),
    .legal  (legal),
    .wr_en  (wr_en)
  );

  assign accept = (state_q == ST_IDLE) && bus.req_valid_i && !bus.flush_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.req_valid_i) state_d = legal ? ST_READ : ST_RESP;
        ST_READ:  state_d = ST_WRITE;
        ST_WRITE: state_d = ST_RESP;
        ST_RESP:  if (bus.resp_ready_i) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      op_q   <= '0;
      src_q  <= '0;
      old_q  <= '0;
      wen_q  <= 1'b0;
      exc_q  <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.csr_addr_i;
      op_q   <= bus.funct3_i[1:0];
      src_q  <= bus.funct3_i[2] ? {{(XLEN-5){1'b0}}, bus.zimm_i} : bus.rs1_data_i;
      old_q  <= '0;
      wen_q  <= wr_en;
      exc_q  <= !legal;
    end else if (state_q == ST_READ) begin
      old_q  <= bus.csr_rdata_i;
    end
  end

  always_comb begin
    case (op_q)
      OP_RW:   wdata = src_q;
      OP_RS:   wdata = old_q | src_q;
      default: wdata = old_q & ~src_q;
    endcase
  end

  always_comb begin
    bus.req_ready_o  = state_q == ST_IDLE;
    bus.csr_raddr_o  = (state_q == ST_READ) ? addr_q : '0;
    bus.csr_waddr_o  = (state_q == ST_WRITE) ? addr_q : '0;
    bus.csr_wdata_o  = (state_q == ST_WRITE) ? wdata : '0;
    // A flush landing on the WRITE cycle must kill the write in that same cycle.
    bus.csr_wen_o    = (state_q == ST_WRITE) && wen_q && !bus.flush_i;
    bus.resp_valid_o = state_q == ST_RESP;
    bus.resp_rdata_o = (state_q == ST_RESP) ? old_q : '0;
    bus.exception_o  = (state_q == ST_RESP) && exc_q;
    bus.cause_o      = ((state_q == ST_RESP) && exc_q) ? XLEN'(ILLEGAL_CAUSE) : '0;
  end

endmodule
